// File: rtl/ram4x4_pkg.sv
// Shared types and constants for the programmable 4x4 lookup table writer.
package ram4x4_pkg;

  localparam int unsigned ADDR_W_DEF = 2;
  localparam int unsigned DATA_W_DEF = 4;

  typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

  // Number of words addressable with an address of the given width.
  function automatic int unsigned depth_of(input int unsigned addr_w);
    return 1 << addr_w;
  endfunction

endpackage

// File: rtl/ram4x4_array.sv
// Storage array: one synchronous write port, async clear, one combinational read port.
module ram4x4_array
  import ram4x4_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int unsigned DEPTH = depth_of(ADDR_W);

  logic [DATA_W-1:0] mem [DEPTH];

  // Clear every word on reset; otherwise store on write enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read-during-write returns the old word until the write edge.
  assign rdata = mem[raddr];

endmodule

// File: rtl/ram4x4_writer.sv
// Burst writer for the programmable 4x4 table: valid/ready stream in, wrapping address,
// combinational read port out. Define RAMWR_OVERRUN_EN to add the sticky overrun flag.
module ram4x4_writer
  import ram4x4_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   count,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              busy,
  output logic              done,
  input  logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] datos
`ifdef RAMWR_OVERRUN_EN
  ,
  output logic              overrun
`endif
);

  // DEPTH expressed in the width of the count port.
  localparam logic [ADDR_W:0] DepthCnt = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] CntOne   = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q;
  logic [ADDR_W:0]   remaining_q;
  logic [ADDR_W:0]   eff_count;
  logic              load;
  logic              accept;

  // Zero means a full table; anything larger than the table is clamped.
  assign eff_count = ((count == '0) || (count > DepthCnt)) ? DepthCnt : count;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d  = state_q;
    wr_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    load     = 1'b0;
    accept   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          load    = 1'b1;
          state_d = StWrite;
        end
      end
      StWrite: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        if (wr_valid) begin
          accept = 1'b1;
          if (remaining_q == CntOne) begin
            state_d = StDone;
          end
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Write pointer wraps naturally at the address width; counter tracks words left.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      remaining_q <= '0;
    end else if (load) begin
      wr_ptr_q    <= base_addr;
      remaining_q <= eff_count;
    end else if (accept) begin
      wr_ptr_q    <= wr_ptr_q + ADDR_W'(1);
      remaining_q <= remaining_q - CntOne;
    end
  end

`ifdef RAMWR_OVERRUN_EN
  // Sticky flag for words offered while not ready; a new error wins over a same-edge start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overrun <= 1'b0;
    end else if (wr_valid && !wr_ready) begin
      overrun <= 1'b1;
    end else if (load) begin
      overrun <= 1'b0;
    end
  end
`endif

  ram4x4_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (accept),
    .waddr (wr_ptr_q),
    .wdata (wr_data),
    .raddr (address),
    .rdata (datos)
  );

endmodule

// File: tb/tb_ram4x4_writer.sv
// Self-checking bench for ram4x4_writer: directed test-plan bursts plus random bursts,
// checked against a transaction-level table model.
module tb_ram4x4_writer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [1:0] base_addr;
  logic [2:0] count;
  logic       wr_valid;
  logic [3:0] wr_data;
  logic       wr_ready;
  logic       busy;
  logic       done;
  logic [1:0] address;
  logic [3:0] datos;
`ifdef RAMWR_OVERRUN_EN
  logic       overrun;
`endif

  int checks = 0;
  int fails  = 0;

  // Reference table contents.
  logic [3:0] mem_m [4];

  ram4x4_writer dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .wr_valid  (wr_valid),
    .wr_data   (wr_data),
    .wr_ready  (wr_ready),
    .busy      (busy),
    .done      (done),
    .address   (address),
    .datos     (datos)
`ifdef RAMWR_OVERRUN_EN
    ,
    .overrun   (overrun)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ready"}, {7'd0, wr_ready}, 8'd0);
    check({tag, "_busy"}, {7'd0, busy}, 8'd0);
    check({tag, "_done"}, {7'd0, done}, 8'd0);
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      check(tag, {4'd0, datos}, {4'd0, mem_m[a]});
    end
  endtask

  // One complete burst. Each word is preceded by a stall of min_st..max_st cycles.
  // With noise set, start/base_addr/count are scrambled while the burst runs.
  task automatic burst(input logic [1:0] base, input logic [2:0] cnt,
                       input int min_st, input int max_st, input bit noise);
    int         n;
    int         st;
    logic [1:0] ptr;
    logic [3:0] d;
    n   = ((cnt == 3'd0) || (cnt > 3'd4)) ? 4 : int'(cnt);
    ptr = base;
    start     = 1'b1;
    base_addr = base;
    count     = cnt;
    wr_valid  = 1'b0;
    #1;
    check("pre_start_ready", {7'd0, wr_ready}, 8'd0);
    step();
    start = 1'b0;
    check("start_ready", {7'd0, wr_ready}, 8'd1);
    check("start_busy", {7'd0, busy}, 8'd1);
`ifdef RAMWR_OVERRUN_EN
    check("overrun_cleared", {7'd0, overrun}, 8'd0);
`endif
    for (int i = 0; i < n; i++) begin
      st = $urandom_range(max_st, min_st);
      for (int s = 0; s < st; s++) begin
        wr_valid = 1'b0;
        wr_data  = 4'($urandom);
        if (noise) begin
          start     = 1'($urandom);
          base_addr = 2'($urandom);
          count     = 3'($urandom);
        end
        step();
        check("stall_busy", {7'd0, busy}, 8'd1);
        check("stall_done", {7'd0, done}, 8'd0);
      end
      d        = 4'($urandom);
      wr_valid = 1'b1;
      wr_data  = d;
      if (noise) begin
        start     = 1'($urandom);
        base_addr = 2'($urandom);
        count     = 3'($urandom);
      end
      address = ptr;
      #1;
      check("rdw_old", {4'd0, datos}, {4'd0, mem_m[ptr]});
      check("accept_ready", {7'd0, wr_ready}, 8'd1);
      step();
      mem_m[ptr] = d;
      wr_valid   = 1'b0;
      start      = 1'b0;
      address    = ptr;
      #1;
      check("word_visible", {4'd0, datos}, {4'd0, d});
      if (i < n - 1) begin
        check("mid_done", {7'd0, done}, 8'd0);
        check("mid_busy", {7'd0, busy}, 8'd1);
      end
      ptr = ptr + 2'd1;
    end
    // Now in the done cycle; a start here must be ignored.
    start = noise ? 1'b1 : 1'b0;
    check("done_pulse", {7'd0, done}, 8'd1);
    check("done_busy", {7'd0, busy}, 8'd0);
    check("done_ready", {7'd0, wr_ready}, 8'd0);
    step();
    start = 1'b0;
    check_quiet("after_done");
    check_mem("burst_mem");
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    wr_valid  = 1'b0;
    wr_data   = '0;
    address   = '0;
    for (int a = 0; a < 4; a++) mem_m[a] = '0;

    // Reset state.
    step();
    step();
    check_quiet("reset");
    check_mem("reset_mem");
`ifdef RAMWR_OVERRUN_EN
    check("reset_overrun", {7'd0, overrun}, 8'd0);
`endif
    rst_n = 1'b1;
    step();
    check_quiet("post_reset");

    // Full burst, wrap with stalls, count=0, clamped count, noisy burst.
    burst(2'd0, 3'd4, 0, 0, 1'b0);
    burst(2'd3, 3'd2, 3, 3, 1'b0);
    burst(2'd2, 3'd0, 0, 0, 1'b0);
    burst(2'd1, 3'd7, 0, 1, 1'b0);
    burst(2'd0, 3'd4, 1, 2, 1'b1);

    // Stray words while idle are dropped.
    wr_valid = 1'b1;
    wr_data  = 4'($urandom);
    step();
    step();
    check_quiet("stray_idle");
`ifdef RAMWR_OVERRUN_EN
    check("overrun_set", {7'd0, overrun}, 8'd1);
    wr_valid = 1'b0;
    step();
    check("overrun_sticky", {7'd0, overrun}, 8'd1);
`endif
    wr_valid = 1'b0;
    check_mem("stray_mem");

    // Random bursts.
    for (int k = 0; k < 30; k++) begin
      burst(2'($urandom), 3'($urandom), 0, 2, 1'($urandom));
    end

    // Reset in the middle of a burst.
    start     = 1'b1;
    base_addr = 2'd1;
    count     = 3'd4;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      wr_valid = 1'b1;
      wr_data  = 4'($urandom);
      step();
    end
    wr_valid = 1'b0;
    check("pre_abort_busy", {7'd0, busy}, 8'd1);
    rst_n = 1'b0;
    #1;
    for (int a = 0; a < 4; a++) mem_m[a] = '0;
    check_quiet("abort");
    check_mem("abort_mem");
    step();
    rst_n = 1'b1;
    step();
    check_quiet("abort_after");
    step();
    check_quiet("abort_after2");
    check_mem("abort_mem2");

    // Writer is usable again after the abort.
    burst(2'($urandom), 3'd3, 0, 1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/ram4x4_writer.md
Name: ram4x4_writer

Overview:
- Write-side counterpart of the team's 4x4 lookup memory.
- Holds a small writable array (DEPTH words of DATA_W bits) and loads it in bursts through a valid/ready stream with an auto-incrementing, wrapping address.
- Exposes the same combinational address-to-data read port as the ROM, so readers can use it as a drop-in programmable table.

Parameters:
- ADDR_W, 2, address width; DEPTH = 2**ADDR_W words.
- DATA_W, 4, word width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to begin a burst; sampled only in IDLE.
- base_addr  in  ADDR_W  first write address, latched on accepted start.
- count  in  ADDR_W+1  words in the burst, latched on accepted start; 0 is treated as DEPTH, values above DEPTH are clamped to DEPTH.
- wr_valid  in  1  wr_data is valid this cycle.
- wr_data  in  DATA_W  word to store.
- wr_ready  out  1  writer accepts a word this cycle.
- busy  out  1  burst in progress (WRITE state).
- done  out  1  one-cycle pulse when the burst completes.
- address  in  ADDR_W  read address.
- datos  out  DATA_W  combinational read data, mem[address].
- overrun  out  1  sticky error flag; present only with RAMWR_OVERRUN_EN.

Behaviour:
- Reset (async assert, sync-released use):
  - state=IDLE; wr_ptr=0; remaining=0.
  - wr_ready=0, busy=0, done=0, overrun=0.
  - All memory words cleared to 0; datos therefore reads 0.
- States: IDLE, WRITE, DONE.
- IDLE:
  - wr_ready=0.
  - start=1: latch wr_ptr=base_addr and remaining=effective count (0 maps to DEPTH, >DEPTH clamps to DEPTH); go to WRITE next cycle.
  - wr_valid in IDLE is ignored.
- WRITE:
  - wr_ready=1, busy=1.
  - On each edge with wr_valid=1: mem[wr_ptr]<=wr_data; wr_ptr<=wr_ptr+1 modulo DEPTH; remaining<=remaining-1.
  - When the accepted word is the last one (remaining==1), go to DONE.
  - wr_valid=0 stalls with no state change; there is no timeout.
- DONE:
  - done=1, wr_ready=0, busy=0 for exactly one cycle; then IDLE.
  - A start in DONE is ignored.
- Latency:
  - start to wr_ready=1 is 1 cycle.
  - A word is visible on datos the cycle after its accepting edge.
  - The last accept to the done pulse is 1 cycle.
- Read port:
  - Purely combinational, no clock.
  - Read-during-write to the same address returns the old word until the write edge.
- Wrap-around: base_addr=DEPTH-1 with count=2 writes DEPTH-1, then 0.
- A burst of DEPTH words overwrites every location exactly once.
- start during WRITE is ignored; base_addr and count changes mid-burst have no effect.
- Reset mid-burst:
  - Aborts immediately to IDLE and clears the memory.
  - done is not pulsed.

Optional Feature:
- RAMWR_OVERRUN_EN defined:
  - Adds the overrun output.
  - overrun is set on any edge where wr_valid=1 and wr_ready=0 (a word offered while IDLE or DONE).
  - Sticky; cleared only by reset or by an accepted start.
- RAMWR_OVERRUN_EN not defined:
  - No overrun port and no logic.
  - Stray wr_valid is silently dropped.

Decomposition:
- Shared package ram4x4_pkg holds:
  - the state enum (IDLE, WRITE, DONE);
  - default ADDR_W and DATA_W constants;
  - a DEPTH function/constant.
- One sub-module, ram4x4_array: the storage with one synchronous write port (we, waddr, wdata), async clear on rst_n, and one combinational read port.
- ram4x4_writer holds the FSM, pointer and counter, and instantiates ram4x4_array.

Test Plan:
- Reset: rst_n=0 then 1; read addresses 0..3 -> datos=0 each; wr_ready=0, busy=0, done=0.
- Full burst: start with base_addr=0, count=4; send A,B,C,D back-to-back.
  - wr_ready rises 1 cycle after start.
  - done pulses 1 cycle after D is accepted.
  - Reads 0..3 -> A,B,C,D.
- Wrap and stall:
  - start with base_addr=3, count=2; send 5, hold wr_valid=0 for 3 cycles, send 9.
  - mem[3]=5, mem[0]=9, others unchanged; busy stays 1 throughout the stall.
- count=0: start with base_addr=2, count=0; send 1,2,3,4 -> mem[2]=1, mem[3]=2, mem[0]=3, mem[1]=4; done after the 4th word.
- Ignored and abort cases:
  - A start pulse during WRITE causes no restart.
  - rst_n low after 2 of 4 words -> IDLE, all reads 0, no done pulse.
- RAMWR_OVERRUN_EN: wr_valid=1 in IDLE -> overrun=1 next cycle and held; the next accepted start -> overrun=0.
